// File: rtl/bram_arb_pkg.sv
// Shared definitions for the two-port bram arbiter: FSM states and port indices.
package bram_arb_pkg;

    localparam int ARB_NUM_PORTS   = 2;
    localparam int ARB_PORT_IFETCH = 0;
    localparam int ARB_PORT_LSU    = 1;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bram_arbiter.sv
// Shares one single-port bram between two masters, with lockable exclusive access.
// Define BRAM_ARB_RR_EN for round-robin arbitration in idle; otherwise port 0 has priority.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [1:0]            i_req,
    input  logic [1:0]            i_we,
    input  logic [1:0]            i_lock,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [DATA_WIDTH-1:0] i_wdata0,
    input  logic [DATA_WIDTH-1:0] i_wdata1,
    output logic [1:0]            o_gnt,
    output logic [1:0]            o_rvalid,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_bram_write,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    output logic [DATA_WIDTH-1:0] o_bram_data,
    input  logic [DATA_WIDTH-1:0] i_bram_data
);

    arb_state_e            state_q, state_d;
    logic [1:0]            gnt;
    logic                  prefer1;
    logic [1:0]            rd_pend_q;
    logic [1:0]            rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;

`ifdef BRAM_ARB_RR_EN
    logic rr_q;

    // Pointer names the preferred port; it flips to the other port after every access.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_q <= 1'b0;
        end else if (gnt[0]) begin
            rr_q <= 1'b1;
        end else if (gnt[1]) begin
            rr_q <= 1'b0;
        end
    end

    assign prefer1 = rr_q;
`else
    assign prefer1 = 1'b0;
`endif

    always_comb begin
        gnt = 2'b00;
        case (state_q)
            ARB_IDLE: begin
                if (i_req[0] && i_req[1]) begin
                    gnt = prefer1 ? 2'b10 : 2'b01;
                end else begin
                    gnt = i_req;
                end
            end
            ARB_LOCK0: gnt = {1'b0, i_req[0]};
            ARB_LOCK1: gnt = {i_req[1], 1'b0};
            default:   gnt = 2'b00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (gnt[0] && i_lock[0]) begin
                    state_d = ARB_LOCK0;
                end else if (gnt[1] && i_lock[1]) begin
                    state_d = ARB_LOCK1;
                end
            end
            ARB_LOCK0: if (gnt[0] && !i_lock[0]) state_d = ARB_IDLE;
            ARB_LOCK1: if (gnt[1] && !i_lock[1]) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Without a grant the bram sees the last address/data so its inputs do not toggle.
    always_comb begin
        o_bram_addr  = addr_q;
        o_bram_data  = data_q;
        o_bram_write = |(gnt & i_we);
        if (gnt[1]) begin
            o_bram_addr = i_addr1;
            o_bram_data = i_wdata1;
        end else if (gnt[0]) begin
            o_bram_addr = i_addr0;
            o_bram_data = i_wdata0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ARB_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            rd_pend_q <= 2'b00;
            rvalid_q  <= 2'b00;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= o_bram_addr;
            data_q    <= o_bram_data;
            rd_pend_q <= gnt & ~i_we;
            rvalid_q  <= rd_pend_q;
            // bram output is valid the cycle after acceptance; register it for the owner.
            if (|rd_pend_q) begin
                rdata_q <= i_bram_data;
            end
        end
    end

    assign o_gnt    = gnt;
    assign o_rvalid = rvalid_q;
    assign o_rdata  = rdata_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural bram and a read-return scoreboard.
module tb_bram_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  lock;
    logic [9:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] rdata;
    logic        bram_write;
    logic [9:0]  bram_addr;
    logic [31:0] bram_wdata;
    logic [31:0] bram_rdata;

    logic [31:0] mem [0:1023];

    int checks   = 0;
    int failures = 0;

    logic        exp_port_q [$];
    logic [31:0] exp_data_q [$];

    bram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req        (req),
        .i_we         (we),
        .i_lock       (lock),
        .i_addr0      (addr0),
        .i_addr1      (addr1),
        .i_wdata0     (wdata0),
        .i_wdata1     (wdata1),
        .o_gnt        (gnt),
        .o_rvalid     (rvalid),
        .o_rdata      (rdata),
        .o_bram_write (bram_write),
        .o_bram_addr  (bram_addr),
        .o_bram_data  (bram_wdata),
        .i_bram_data  (bram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous bram, read-before-write.
    always @(posedge clk) begin
        if (bram_write) mem[bram_addr] <= bram_wdata;
        bram_rdata <= mem[bram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant legality every cycle, and read returns against the scoreboard.
    always @(negedge clk) begin
        chk("gnt_legal", ((gnt & ~req) == 2'b00) && ($countones(gnt) <= 1), 1);
        if (rvalid !== 2'b00) begin
            if (exp_port_q.size() == 0) begin
                chk("rvalid_unexpected", rvalid, 2'b00);
            end else begin
                logic        p;
                logic [31:0] d;
                p = exp_port_q.pop_front();
                d = exp_data_q.pop_front();
                chk("rvalid_port", rvalid, p ? 2'b10 : 2'b01);
                chk("rdata", rdata, d);
            end
        end
    end

    task automatic push_exp(input logic p, input logic [31:0] d);
        exp_port_q.push_back(p);
        exp_data_q.push_back(d);
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic lk,
                         input logic [9:0] a, input logic [31:0] d);
        req[p]  = r;
        we[p]   = w;
        lock[p] = lk;
        if (p == 0) begin addr0 = a; wdata0 = d; end
        else begin addr1 = a; wdata1 = d; end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic do_access(input int p, input logic w, input logic lk, input logic [9:0] a,
                             input logic [31:0] d, input logic [31:0] exp, input bit immediate);
        bit done = 0;
        int waited = 0;
        drive(p, 1'b1, w, lk, a, d);
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (gnt[p]) begin
                done = 1;
                if (!w) push_exp(p[0], exp);
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        chk("grant_timeout", done, 1);
        if (immediate) chk("grant_wait", waited, 0);
        drive(p, 1'b0, 1'b0, 1'b0, a, d);
    endtask

    initial begin
        rst_n = 1'b0;
        req = 2'b00; we = 2'b00; lock = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bram_write", bram_write, 0);
        chk("rst_bram_addr", bram_addr, 0);
        chk("rst_bram_data", bram_wdata, 0);
        chk("rst_rdata", rdata, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single port 1 write then read.
        do_access(1, 1'b1, 1'b0, 10'd5, 32'hAABBCCDD, 32'h0, 1);
        do_access(1, 1'b0, 1'b0, 10'd5, 32'h0, 32'hAABBCCDD, 1);
        do_access(1, 1'b1, 1'b0, 10'd3, 32'd7, 32'h0, 1);

        // Contention: both ports read every cycle.
        drive(0, 1'b1, 1'b0, 1'b0, 10'd5, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 10'd5, 32'h0);
        for (int k = 0; k < 4; k++) begin
            logic [1:0] eg;
`ifdef BRAM_ARB_RR_EN
            eg = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            eg = 2'b01;
`endif
            @(negedge clk);
            chk("contention_gnt", gnt, eg);
            push_exp(eg[1], 32'hAABBCCDD);
            @(posedge clk);
            #1;
        end
        drive(0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 10'd0, 32'h0);

        // Read then write same address returns old data.
        do_access(0, 1'b0, 1'b0, 10'd5, 32'h0, 32'hAABBCCDD, 1);
        do_access(0, 1'b1, 1'b0, 10'd5, 32'h12345678, 32'h0, 1);
        do_access(0, 1'b0, 1'b0, 10'd5, 32'h0, 32'h12345678, 1);

        // Lock: port 1 read-modify-write of addr 3 while port 0 keeps requesting.
        drive(1, 1'b1, 1'b0, 1'b1, 10'd3, 32'h0);
        @(negedge clk);
        chk("lock_rd_gnt", gnt, 2'b10);
        push_exp(1'b1, 32'd7);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 1'b0, 10'd3, 32'h0);
        drive(0, 1'b1, 1'b0, 1'b0, 10'd3, 32'h0);
        @(negedge clk);
        chk("lock_hold_gnt", gnt, 2'b00);
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 1'b0, 10'd3, 32'd8);
        @(negedge clk);
        chk("lock_wr_gnt", gnt, 2'b10);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 1'b0, 10'd3, 32'h0);
        @(negedge clk);
        chk("unlock_p0_gnt", gnt, 2'b01);
        push_exp(1'b0, 32'd8);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 1'b0, 10'd3, 32'h0);
        repeat (3) @(posedge clk);
        #1;

        // Reset in LOCK0 with a read in flight.
        drive(0, 1'b1, 1'b0, 1'b1, 10'd3, 32'h0);
        @(negedge clk);
        chk("lock0_gnt", gnt, 2'b01);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 10'd3, 32'h0);
        #3;
        chk("midrst_gnt", gnt, 0);
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_bram_write", bram_write, 0);
        chk("midrst_bram_addr", bram_addr, 0);
        chk("midrst_bram_data", bram_wdata, 0);
        chk("midrst_rdata", rdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1, 1'b1, 1'b0, 1'b0, 10'd3, 32'h0);
        @(negedge clk);
        chk("post_rst_p1_gnt", gnt, 2'b10);
        push_exp(1'b1, 32'd8);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 1'b0, 10'd3, 32'h0);

        // Loop: back-to-back writes then reads from port 0.
        for (int i = 0; i < 32; i++) begin
            do_access(0, 1'b1, 1'b0, 10'(2 * i + 1), 32'(i + 1), 32'h0, 1);
        end
        for (int i = 0; i < 32; i++) begin
            do_access(0, 1'b0, 1'b0, 10'(2 * i + 1), 32'h0, 32'(i + 1), 1);
        end
        @(negedge clk);
        chk("idle_bram_write", bram_write, 0);
        chk("idle_bram_addr_hold", bram_addr, 10'd63);

        for (int c = 0; c < 10 && exp_port_q.size() != 0; c++) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", exp_port_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
